store_buffer: RTL
=================

Name: store_buffer

Overview:
- Sits between the pipelined core's memory-stage data port and the backing data RAM.
- The RAM accepts one request at a time with a ready handshake.
- Stores are absorbed into a DEPTH-entry FIFO and drained in the background.
- Loads bypass the buffer when they do not conflict with a buffered store; otherwise they wait for the conflicting stores to drain. A stall output goes to the core hazard logic.

Parameters:
- N, 64: data and address width.
- DEPTH, 4: store FIFO entries (power of two, at least 2).

Ports:
- clk  input  1  clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- dataadr  input  N  core byte address (memory stage).
- writedata  input  N  core store data, right-aligned.
- memwrite  input  2  store size: 00 none, 01 byte, 10 word (32b), 11 dword.
- memread  input  1  load request (memory stage).
- dword  input  1  load size: 1 = 64b, 0 = 32b.
- readdata  output  N  load result.
- stall  output  1  core must hold the memory stage and its inputs.
- mem_req  output  1  RAM request valid.
- mem_we  output  1  1 = write, 0 = read.
- mem_adr  output  N  dword-aligned RAM address (low 3 bits zero).
- mem_wdata  output  N  lane-aligned write data.
- mem_wmask  output  8  byte-lane enables.
- mem_ready  input  1  RAM completes the current request this cycle.
- mem_rdata  input  N  RAM read data, valid with mem_ready.

Behaviour:
- Reset (reset=0, async): FIFO empty, count=0, state IDLE.
  - Outputs: readdata=0, stall=0, mem_req=0, mem_we=0, mem_adr=0, mem_wdata=0, mem_wmask=0.
- Entry format: {dword address adr[N-1:3], 64b lane data, 8b mask}.
- Lane formation:
  - Byte: lane adr[2:0], mask one bit.
  - Word: lanes 7:4 if adr[2] else 3:0, adr[1:0] ignored.
  - Dword: all lanes, adr[2:0] ignored.
  - Data is shifted into the selected lanes; lanes outside the mask are 0.
- Store acceptance: memwrite!=00 and registered count<DEPTH → entry enqueued at the rising edge, stall=0.
  - If count==DEPTH, stall=1 and nothing is enqueued; the core holds the store until accepted.
  - Stall is a function of registered count only. A drain completing in the same cycle does not admit a store on a full buffer.
- memread and memwrite never assert together; if they do, the store wins and the load is ignored.
- Conflict: a load conflicts if any valid entry has the same dword address.
- States: IDLE, WRITE, READ, RDONE.
- IDLE:
  - Non-conflicting load present → READ; stall=1 from the first cycle the load is presented.
  - Else if FIFO non-empty → WRITE, with head entry on mem_* and mem_we=1.
  - A conflicting load keeps stall=1; IDLE continues draining via WRITE until no conflict remains.
- WRITE: mem_req=1 with head entry held stable. On mem_ready, the head is dequeued → IDLE. No new write is issued in that same cycle (minimum 1 idle cycle between requests).
- READ:
  - mem_req=1, mem_we=0, mem_adr=dataadr with low 3 bits cleared, mem_wmask=0.
  - On mem_ready, readdata is registered → RDONE.
- Read formatting:
  - dword=1: readdata=mem_rdata.
  - dword=0: readdata is the word selected by adr[2], zero-extended to N; the core performs sign and byte extension.
- RDONE: stall=0 for exactly one cycle; the core consumes readdata → IDLE. readdata holds its value until the next load completes.
- Load priority: loads take priority over draining, but only at IDLE; an in-flight write is never aborted.
- Simultaneous enqueue and dequeue: count unchanged, pointers wrap modulo DEPTH.
- Reset mid-request: in-flight RAM transaction abandoned, mem_req drops immediately, buffered stores discarded.

Decomposition:
- Package sb_pkg:
  - memwrite encodings (MW_NONE/BYTE/WORD/DWORD).
  - state enum.
  - entry struct.
  - lane-formation function (shared with the bench model).
- Sub-module sb_fifo: circular buffer with DEPTH entries, push/pop, count, full/empty, plus a combinational per-entry address-match output (any_match).

Test Plan:
- Store dword 0x1122334455667788 @0x100; mem_ready tied 1 → stall=0; next cycle mem_req=1, mem_we=1, mem_adr=0x100, mask=0xFF; count returns to 0.
- Byte store 0xAB @0x105 → mem_wdata=0x0000AB0000000000, mask=0x20; word store 0xDEADBEEF @0x10C → mask=0xF0, data in lanes 7:4.
- mem_ready held 0, five consecutive stores → first four accepted, fifth sees stall=1 until the first mem_ready pulse, then enqueues; drain order is FIFO.
- Store @0x200 buffered, mem_ready=0, then load dword @0x208 → READ issued ahead of the drain; mem_rdata=0xCAFE with ready → RDONE; readdata=0xCAFE with stall low for one cycle.
- Store @0x300 buffered, then 32b load @0x304 → stall held through the write drain, then read; readdata equals the upper word of mem_rdata, zero-extended.
- Assert reset low during WRITE with 3 entries queued → mem_req=0 immediately, count=0; after release the buffer is idle with no writes issued.

Source files
------------

// File: rtl/sb_pkg.sv
// rtl/sb_pkg.sv - store buffer shared types, encodings and lane formation
package sb_pkg;

   localparam int SB_N = 64;

   typedef enum logic [1:0] {
      MW_NONE  = 2'b00,
      MW_BYTE  = 2'b01,
      MW_WORD  = 2'b10,
      MW_DWORD = 2'b11
   } mw_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_WRITE,
      ST_READ,
      ST_RDONE
   } state_e;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  mask;
   } lane_t;

   typedef struct packed {
      logic [SB_N-4:0] dadr;
      logic [63:0]     data;
      logic [7:0]      mask;
   } entry_t;

   // Right-aligned store data moved into its byte lanes; lanes outside the mask stay zero.
   function automatic lane_t form_lanes(input logic [1:0] mw, input logic [2:0] adr,
                                        input logic [63:0] wdata);
      lane_t l;
      l = '0;
      case (mw)
         MW_BYTE: begin
            l.mask = 8'b1 << adr;
            l.data = {56'b0, wdata[7:0]} << {adr, 3'b000};
         end
         MW_WORD: begin
            l.mask = adr[2] ? 8'hF0 : 8'h0F;
            l.data = adr[2] ? {wdata[31:0], 32'b0} : {32'b0, wdata[31:0]};
         end
         MW_DWORD: begin
            l.mask = 8'hFF;
            l.data = wdata;
         end
         default: l = '0;
      endcase
      return l;
   endfunction

endpackage

// File: rtl/store_buffer_if.sv
// rtl/store_buffer_if.sv - core memory-stage port and RAM request port of the store buffer
interface store_buffer_if #(parameter int N = 64);

   logic [N-1:0] dataadr;
   logic [N-1:0] writedata;
   logic [1:0]   memwrite;
   logic         memread;
   logic         dword;
   logic [N-1:0] readdata;
   logic         stall;
   logic         mem_req;
   logic         mem_we;
   logic [N-1:0] mem_adr;
   logic [N-1:0] mem_wdata;
   logic [7:0]   mem_wmask;
   logic         mem_ready;
   logic [N-1:0] mem_rdata;

   modport slave (
      input  dataadr, writedata, memwrite, memread, dword, mem_ready, mem_rdata,
      output readdata, stall, mem_req, mem_we, mem_adr, mem_wdata, mem_wmask
   );

   modport master (
      output dataadr, writedata, memwrite, memread, dword, mem_ready, mem_rdata,
      input  readdata, stall, mem_req, mem_we, mem_adr, mem_wdata, mem_wmask
   );

endinterface

// File: rtl/sb_fifo.sv
// rtl/sb_fifo.sv - circular store FIFO with a dword-address match across valid entries
module sb_fifo
   import sb_pkg::*;
#(
   parameter int DEPTH = 4,
   localparam int PW = $clog2(DEPTH),
   localparam int CW = PW + 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            i_push,
   input  entry_t          i_push_entry,
   input  logic            i_pop,
   output entry_t          o_head,
   output logic [CW-1:0]   o_count,
   output logic            o_full,
   input  logic [SB_N-4:0] i_match_dadr,
   output logic            o_any_match
);

   entry_t          r_mem [DEPTH];
   logic [PW-1:0]   r_wr;
   logic [PW-1:0]   r_rd;
   logic [CW-1:0]   r_count;
   logic [PW-1:0]   w_off;
   logic            w_match;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wr    <= '0;
         r_rd    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + 1'b1;
         if (i_pop)  r_rd <= r_rd + 1'b1;
         case ({i_push, i_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (i_push) r_mem[r_wr] <= i_push_entry;
   end

   // An entry is live when its distance from the read pointer is below the count.
   always_comb begin
      w_match = 1'b0;
      w_off   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         w_off = PW'(i) - r_rd;
         if (({1'b0, w_off} < r_count) && (r_mem[i].dadr == i_match_dadr)) w_match = 1'b1;
      end
   end

   assign o_head      = r_mem[r_rd];
   assign o_count     = r_count;
   assign o_full      = (r_count == CW'(DEPTH));
   assign o_any_match = w_match;

endmodule

// File: rtl/store_buffer.sv
// rtl/store_buffer.sv - store buffer: absorbs core stores, drains to RAM, lets loads bypass
module store_buffer
   import sb_pkg::*;
#(
   parameter int N     = SB_N,
   parameter int DEPTH = 4,
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic           clk,
   input  logic           reset,
   store_buffer_if.slave  bus
);

   state_e        r_state;
   logic          r_mem_req;
   logic          r_mem_we;
   logic [N-1:0]  r_mem_adr;
   logic [N-1:0]  r_mem_wdata;
   logic [7:0]    r_mem_wmask;
   logic [N-1:0]  r_readdata;

   lane_t         w_lane;
   entry_t        w_push_entry;
   entry_t        w_head;
   logic [CW-1:0] w_count;
   logic          w_full;
   logic          w_empty;
   logic          w_store;
   logic          w_load;
   logic          w_push;
   logic          w_pop;
   logic          w_conflict;
   logic          w_stall;
   logic [31:0]   w_word;
   logic [N-1:0]  w_read_fmt;

   assign w_store      = (bus.memwrite != MW_NONE);
   assign w_load       = bus.memread && !w_store;
   assign w_lane       = form_lanes(bus.memwrite, bus.dataadr[2:0], bus.writedata);
   assign w_push_entry = '{dadr: bus.dataadr[N-1:3], data: w_lane.data, mask: w_lane.mask};
   assign w_empty      = (w_count == '0);
   assign w_push       = w_store && !w_full;
   assign w_pop        = (r_state == ST_WRITE) && bus.mem_ready;

   // Full-buffer stall looks only at the registered count, so a same-cycle drain does not help.
   assign w_stall = (w_store && w_full) || (w_load && (r_state != ST_RDONE));

   assign w_word     = bus.dataadr[2] ? bus.mem_rdata[63:32] : bus.mem_rdata[31:0];
   assign w_read_fmt = bus.dword ? bus.mem_rdata : {{(N-32){1'b0}}, w_word};

   sb_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk          (clk),
      .reset        (reset),
      .i_push       (w_push),
      .i_push_entry (w_push_entry),
      .i_pop        (w_pop),
      .o_head       (w_head),
      .o_count      (w_count),
      .o_full       (w_full),
      .i_match_dadr (bus.dataadr[N-1:3]),
      .o_any_match  (w_conflict)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state     <= ST_IDLE;
         r_mem_req   <= 1'b0;
         r_mem_we    <= 1'b0;
         r_mem_adr   <= '0;
         r_mem_wdata <= '0;
         r_mem_wmask <= '0;
         r_readdata  <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_load && !w_conflict) begin
                  r_state     <= ST_READ;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_adr   <= {bus.dataadr[N-1:3], 3'b000};
                  r_mem_wmask <= '0;
               end else if (!w_empty) begin
                  r_state     <= ST_WRITE;
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b1;
                  r_mem_adr   <= {w_head.dadr, 3'b000};
                  r_mem_wdata <= w_head.data;
                  r_mem_wmask <= w_head.mask;
               end
            end
            ST_WRITE: begin
               if (bus.mem_ready) begin
                  r_state   <= ST_IDLE;
                  r_mem_req <= 1'b0;
                  r_mem_we  <= 1'b0;
               end
            end
            ST_READ: begin
               if (bus.mem_ready) begin
                  r_state    <= ST_RDONE;
                  r_mem_req  <= 1'b0;
                  r_readdata <= w_read_fmt;
               end
            end
            ST_RDONE: r_state <= ST_IDLE;
            default:  r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.stall     = w_stall;
   assign bus.readdata  = r_readdata;
   assign bus.mem_req   = r_mem_req;
   assign bus.mem_we    = r_mem_we;
   assign bus.mem_adr   = r_mem_adr;
   assign bus.mem_wdata = r_mem_wdata;
   assign bus.mem_wmask = r_mem_wmask;

endmodule
